// File: rtl/eb_downsize_if.sv
// Word-to-beat downsizer bus: upstream word handshake (t_0_*) and downstream beat handshake (i_0_*).
interface eb_downsize_if #(
    parameter int WIDTH = 32,
    parameter int RATIO = 4
);
    localparam int OW = WIDTH / RATIO;

    logic             t_0_req;
    logic             t_0_ack;
    logic [WIDTH-1:0] t_0_data;
    logic             i_0_req;
    logic             i_0_ack;
    logic [OW-1:0]    i_0_data;
    logic             i_0_last;

    modport slave (
        input  t_0_req, t_0_data, i_0_ack,
        output t_0_ack, i_0_req, i_0_data, i_0_last
    );

    modport master (
        output t_0_req, t_0_data, i_0_ack,
        input  t_0_ack, i_0_req, i_0_data, i_0_last
    );
endinterface

// File: rtl/eb_downsize.sv
// Splits each WIDTH-bit word into RATIO beats of WIDTH/RATIO bits, LSB slice first.
// Define EB_DOWNSIZE_OVERLAP_EN to accept the next word on the last-beat cycle (no bubble).
module eb_downsize #(
    parameter int WIDTH = 32,
    parameter int RATIO = 4,
    parameter int CNTW  = 2
) (
    input logic         clk,
    input logic         reset_n,
    eb_downsize_if.slave bus
);
    localparam int OW = WIDTH / RATIO;

    logic [WIDTH-1:0]          data_q, data_d;
    logic [CNTW-1:0]           cnt_q, cnt_d;
    logic                      full_q, full_d;
    logic [RATIO-1:0][OW-1:0]  slices;
    logic                      load, beat, last;

    assign slices = data_q;
    assign last   = full_q && (cnt_q == CNTW'(RATIO - 1));
    assign beat   = full_q && bus.i_0_ack;
    assign load   = bus.t_0_req && bus.t_0_ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    // A load overrides the last-beat drain so the register never empties when a word is waiting.
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        full_d = full_q;
        if (beat) begin
            if (last) begin
                cnt_d  = '0;
                full_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CNTW'(1);
            end
        end
        if (load) begin
            data_d = bus.t_0_data;
            cnt_d  = '0;
            full_d = 1'b1;
        end
    end

    always_comb begin
        bus.i_0_req  = full_q;
        bus.i_0_data = slices[cnt_q];
        bus.i_0_last = last;
`ifdef EB_DOWNSIZE_OVERLAP_EN
        bus.t_0_ack  = !full_q || (last && bus.i_0_ack);
`else
        bus.t_0_ack  = !full_q;
`endif
    end
endmodule

// File: tb/tb_eb_downsize.sv
// Directed bench for eb_downsize (WIDTH=32, RATIO=4); expectations follow the build's overlap setting.
module tb_eb_downsize;
    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    eb_downsize_if #(.WIDTH(32), .RATIO(4)) bus ();
    eb_downsize #(.WIDTH(32), .RATIO(4), .CNTW(2)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] words [3];
        logic [7:0]  exp_b [4];
        int widx, beats, first, lastc, idle;
        logic acc;
        logic [7:0] eb;

        words[0] = 32'h13121110;
        words[1] = 32'h23222120;
        words[2] = 32'h33323130;
        exp_b[0] = 8'hAA; exp_b[1] = 8'hBB; exp_b[2] = 8'hCC; exp_b[3] = 8'hDD;

        // reset state
        reset_n = 1'b0;
        bus.t_0_req = 1'b0;
        bus.t_0_data = 32'h0;
        bus.i_0_ack = 1'b0;
        #2;
        chk("rst_req",  {31'b0, bus.i_0_req},  32'd0);
        chk("rst_last", {31'b0, bus.i_0_last}, 32'd0);
        chk("rst_data", {24'b0, bus.i_0_data}, 32'd0);
        chk("rst_tack", {31'b0, bus.t_0_ack},  32'd1);
        step();
        step();
        reset_n = 1'b1;

        // idle acks with no word: nothing may change
        bus.t_0_data = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            bus.i_0_ack = ~bus.i_0_ack;
            step();
            chk("idle_req",  {31'b0, bus.i_0_req},  32'd0);
            chk("idle_tack", {31'b0, bus.t_0_ack},  32'd1);
            chk("idle_data", {24'b0, bus.i_0_data}, 32'd0);
        end

        // single word, LSB slice first, latency 1
        bus.t_0_req = 1'b1;
        bus.t_0_data = 32'hDDCCBBAA;
        bus.i_0_ack = 1'b1;
        #1;
        chk("sw_tack_empty", {31'b0, bus.t_0_ack}, 32'd1);
        step();
        bus.t_0_req = 1'b0;
        bus.t_0_data = 32'h12345678;
        for (int k = 0; k < 4; k++) begin
            chk("sw_req",  {31'b0, bus.i_0_req},  32'd1);
            chk("sw_data", {24'b0, bus.i_0_data}, {24'b0, exp_b[k]});
            chk("sw_last", {31'b0, bus.i_0_last}, (k == 3) ? 32'd1 : 32'd0);
            step();
        end
        chk("sw_req_done",  {31'b0, bus.i_0_req}, 32'd0);
        chk("sw_tack_done", {31'b0, bus.t_0_ack}, 32'd1);

        // downstream stall at beat 2
        bus.t_0_req = 1'b1;
        bus.t_0_data = 32'hDDCCBBAA;
        step();
        bus.t_0_req = 1'b0;
        step();
        step();
        bus.i_0_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("st_data", {24'b0, bus.i_0_data}, 32'h000000CC);
            chk("st_cnt",  {30'b0, dut.cnt_q},    32'd2);
            chk("st_req",  {31'b0, bus.i_0_req},  32'd1);
            chk("st_tack", {31'b0, bus.t_0_ack},  32'd0);
            step();
        end
        bus.i_0_ack = 1'b1;
        #1;
        chk("st_resume_cc", {24'b0, bus.i_0_data}, 32'h000000CC);
        step();
        chk("st_resume_dd", {24'b0, bus.i_0_data}, 32'h000000DD);
        chk("st_resume_last", {31'b0, bus.i_0_last}, 32'd1);
        step();
        chk("st_empty", {31'b0, bus.i_0_req}, 32'd0);

        // streaming three words back to back
        widx = 0; beats = 0; first = -1; lastc = -1; idle = 0;
        bus.t_0_req = 1'b1;
        bus.t_0_data = words[0];
        bus.i_0_ack = 1'b1;
        for (int cyc = 0; cyc < 40 && beats < 12; cyc++) begin
            #1;
            if (bus.i_0_req) begin
                if (first < 0) first = cyc;
                lastc = cyc;
                eb = 8'h10 * 8'(beats / 4 + 1) + 8'(beats % 4);
                chk("str_data", {24'b0, bus.i_0_data}, {24'b0, eb});
                chk("str_last", {31'b0, bus.i_0_last}, (beats % 4 == 3) ? 32'd1 : 32'd0);
                if (bus.i_0_last) begin
`ifdef EB_DOWNSIZE_OVERLAP_EN
                    chk("str_tack_on_last", {31'b0, bus.t_0_ack}, 32'd1);
`else
                    chk("str_tack_on_last", {31'b0, bus.t_0_ack}, 32'd0);
`endif
                end
                beats++;
            end else if (first >= 0) begin
                idle++;
            end
            acc = bus.t_0_req && bus.t_0_ack;
            step();
            if (acc) begin
                widx++;
                if (widx < 3) bus.t_0_data = words[widx];
                else bus.t_0_req = 1'b0;
            end
        end
        chk("str_beats", beats, 32'd12);
`ifdef EB_DOWNSIZE_OVERLAP_EN
        chk("str_span", lastc - first + 1, 32'd12);
        chk("str_idle", idle, 32'd0);
`else
        chk("str_span", lastc - first + 1, 32'd14);
        chk("str_idle", idle, 32'd2);
`endif
        step();
        chk("str_empty", {31'b0, bus.i_0_req}, 32'd0);

        // reset in the middle of a word
        bus.t_0_req = 1'b1;
        bus.t_0_data = 32'hDDCCBBAA;
        step();
        bus.t_0_req = 1'b0;
        step();
        chk("mr_beat1", {24'b0, bus.i_0_data}, 32'h000000BB);
        reset_n = 1'b0;
        #1;
        chk("mr_req_async",  {31'b0, bus.i_0_req}, 32'd0);
        chk("mr_tack_async", {31'b0, bus.t_0_ack}, 32'd1);
        step();
        chk("mr_req",  {31'b0, bus.i_0_req},  32'd0);
        chk("mr_tack", {31'b0, bus.t_0_ack},  32'd1);
        chk("mr_data", {24'b0, bus.i_0_data}, 32'd0);
        reset_n = 1'b1;
        step();
        chk("mr_req_idle", {31'b0, bus.i_0_req}, 32'd0);
        bus.t_0_req = 1'b1;
        bus.t_0_data = 32'h44332211;
        step();
        bus.t_0_req = 1'b0;
        chk("mr_first",      {24'b0, bus.i_0_data}, 32'h00000011);
        chk("mr_first_last", {31'b0, bus.i_0_last}, 32'd0);
        step();
        chk("mr_second", {24'b0, bus.i_0_data}, 32'h00000022);
        step();
        step();
        chk("mr_fourth", {24'b0, bus.i_0_data}, 32'h00000044);
        step();
        chk("mr_done", {31'b0, bus.i_0_req}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
